apb_ram_param: RTL and testbench
================================

# apb_ram_param

Parametrised APB slave RAM, the next-generation APB memory target for the peripheral bus. It has configurable data width, address width, memory depth and wait-state count. Out-of-range accesses return an error response through `pslverr`. Byte-lane write strobes are an optional build feature.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data bus width in bits; multiple of 8, 8..64.
- `ADDR_WIDTH`, 12, `paddr` width in bits (byte address).
- `MEM_DEPTH`, 256, number of words; must be ≤ 2^(`ADDR_WIDTH`−`ADDR_LSB`).
- `WAIT_STATES`, 0, access-phase cycles with `pready` low before completion; 0..15.
- Derived: `ADDR_LSB` = log2(`DATA_WIDTH`/8). Word index = `paddr[ADDR_WIDTH-1:ADDR_LSB]`.

Ports:
- **Clock and reset.** One clock. Reset is asynchronous and active-high.
  - `pclk`, in, 1, bus clock; all logic on the rising edge.
  - `preset`, in, 1, asynchronous reset, active-high.
- **APB request.**
  - `psel`, in, 1, slave select.
  - `penable`, in, 1, access-phase indicator.
  - `pwrite`, in, 1, 1 = write, 0 = read.
  - `paddr`, in, `ADDR_WIDTH`, byte address.
  - `pwdata`, in, `DATA_WIDTH`, write data.
  - `pstrb`, in, `DATA_WIDTH`/8, byte-lane write strobes. Present only with `APB_RAM_STRB_EN`.
- **APB response.**
  - `prdata`, out, `DATA_WIDTH`, registered read data.
  - `pready`, out, 1, transfer complete.
  - `pslverr`, out, 1, error response; valid only while `pready`=1.

## Operation
- **FSM states:** IDLE and ACCESS, plus a wait counter `wcnt` of width clog2(`WAIT_STATES`+1), minimum 1.
- **IDLE:**
  - `psel`=1 and `penable`=0 (setup phase): go to ACCESS, `wcnt`←0.
  - Otherwise stay in IDLE.
- **ACCESS:**
  - `psel`=0 or `penable`=0: abort to IDLE. No write, no `prdata` update, `pready` stays 0.
  - Else if `wcnt`==`WAIT_STATES`: `pready`=1, go to IDLE.
  - Else: `wcnt`←`wcnt`+1, `pready`=0.
- **`pready` and `pslverr`:** combinational from state, `wcnt`, `psel`, `penable`. `pslverr`=1 exactly when `pready`=1 and word index ≥ `MEM_DEPTH`.
- **Write:** committed at the rising edge that ends the `pready`=1 cycle, and only if `pslverr`=0.
- **Read:**
  - The memory read is performed at that same completing edge.
  - In-range read: `prdata` captures `mem[index]`, is visible from the next cycle, and holds until the next completed read.
  - Error read: `prdata` captures 0.
- **Read-data mode:** `prdata` is registered, and completion is signalled one cycle before the data appears. `prdata` is therefore valid in the cycle after `pready`. Masters sample it there; this is the decided mode for this block.
- **Writes and `prdata`:** writes never modify `prdata`.
- **Reset:** memory contents are not reset and are X until written.

## Timing
- **Reset values:** `prdata`=0, `pready`=0, `pslverr`=0, state=IDLE, `wcnt`=0.
- **Reset mid-transfer:** state returns to IDLE immediately (asynchronous). Any pending write is dropped.
- **Latency:** setup cycle, then `WAIT_STATES`+1 access cycles. `pready` is high in access cycle `WAIT_STATES`+1.
  - `WAIT_STATES`=0: `pready`=1 in the first access cycle.
- **Back-to-back:** a setup phase in the cycle after `pready` is accepted without penalty.
- **Address and control:** sampled only in the completing cycle. Changes during wait cycles violate the protocol and are not checked.
- **Address alignment:** `paddr[ADDR_LSB-1:0]` is ignored; unaligned addresses are word-aligned.
- **Boundaries:**
  - Index `MEM_DEPTH`−1 is valid; index `MEM_DEPTH` errors.
  - With `MEM_DEPTH`=2^(`ADDR_WIDTH`−`ADDR_LSB`), `pslverr` is never asserted.

## Configuration
- **Macro:** `APB_RAM_STRB_EN`.
- **Defined:**
  - `pstrb` port exists.
  - On a completing write, only lanes where `pstrb[i]`=1 update `mem[index][8i+7:8i]`; other bytes are preserved.
  - `pstrb`=0 on a write is legal: no byte changes and `pready` still asserts.
  - Reads ignore `pstrb`.
- **Undefined:** `pstrb` port is absent and every completed write updates the full word.

## Test plan
- **Reset, then idle:** assert `preset` for 2 cycles, then hold `psel`=0 for 5 cycles → `prdata`=0, `pready`=0, `pslverr`=0 throughout.
- **Write/read, `WAIT_STATES`=2, `DATA_WIDTH`=32:**
  - Write 0xDEADBEEF to `paddr`=0x010 → `pready` high in the 3rd access cycle, `pslverr`=0.
  - Read `paddr`=0x010 → `prdata`=0xDEADBEEF in the cycle after `pready`.
- **Out-of-range, `MEM_DEPTH`=256, `ADDR_WIDTH`=12:**
  - Write 0x12345678 to `paddr`=0x400 (index 256) → `pready`=1, `pslverr`=1.
  - Read `paddr`=0x3FC (index 255) → `pslverr`=0, and the stored value is unchanged.
- **Strobes (`APB_RAM_STRB_EN`):**
  - Write 0xFFFFFFFF to `paddr`=0x20, then write 0x00000000 with `pstrb`=4'b0101.
  - Read `paddr`=0x20 → `prdata`=0xFF00FF00.
- **Abort and reset mid-transfer, `WAIT_STATES`=3:**
  - Drop `penable` in the 2nd access cycle of a write of 0xA5A5A5A5 to index 4 → no `pready`, FSM returns to IDLE, and a later read of index 4 returns the prior value.
  - Repeat with `preset` pulsed in that cycle → same result.
- **Back-to-back, `WAIT_STATES`=0:** four consecutive writes to indexes 0..3, each setup phase immediately following the previous `pready`, then four reads → `pready` every 2nd cycle, and the data read back matches.

Source files
------------

// File: rtl/apb_ram_param_if.sv
// APB bus bundle for apb_ram_param: request signals from the master, response from the slave.
// pstrb exists only when APB_RAM_STRB_EN is defined.
interface apb_ram_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
`ifdef APB_RAM_STRB_EN
  logic [DATA_WIDTH/8-1:0] pstrb;
`endif
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
`ifdef APB_RAM_STRB_EN
    output pstrb,
`endif
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
`ifdef APB_RAM_STRB_EN
    input  pstrb,
`endif
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_ram_param.sv
// Parametrised APB slave RAM: configurable widths, depth and wait states; out-of-range -> pslverr.
// Build option APB_RAM_STRB_EN adds pstrb byte-lane write strobes; without it every write is full-word.
module apb_ram_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic           pclk,
  input  logic           preset,
  apb_ram_param_if.slave bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = ADDR_WIDTH - ADDR_LSB;
  localparam int MEM_AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int WCNT_WIDTH = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  localparam logic [WCNT_WIDTH-1:0] WCNT_LAST = WCNT_WIDTH'(WAIT_STATES);
  localparam logic [IDX_WIDTH:0]    DEPTH_LIM = (IDX_WIDTH + 1)'(MEM_DEPTH);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 64 ||
      MEM_DEPTH < 1 || MEM_DEPTH > (1 << IDX_WIDTH) ||
      WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_params
    $error("apb_ram_param: illegal parameter combination");
  end

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t                  state_q, state_d;
  logic [WCNT_WIDTH-1:0]   wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic [IDX_WIDTH-1:0]    word_idx;
  logic [MEM_AW-1:0]       mem_idx;
  logic                    in_range;
  logic                    pready;
  logic                    wr_en;
  logic                    rd_en;
  logic [STRB_WIDTH-1:0]   lane_we;

  // The byte-offset bits below ADDR_LSB are dropped, so unaligned addresses hit the containing word.
  assign word_idx = bus.paddr[ADDR_WIDTH-1:ADDR_LSB];
  assign mem_idx  = word_idx[MEM_AW-1:0];
  assign in_range = ({1'b0, word_idx} < DEPTH_LIM);

`ifdef APB_RAM_STRB_EN
  assign lane_we = bus.pstrb;
`else
  assign lane_we = '1;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.psel && !bus.penable) begin
          state_d = S_ACCESS;
          wcnt_d  = '0;
        end
      end
      S_ACCESS: begin
        if (!bus.psel || !bus.penable) begin
          state_d = S_IDLE;
        end else if (wcnt_q == WCNT_LAST) begin
          pready  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_en = pready && bus.pwrite && in_range;
  assign rd_en = pready && !bus.pwrite;

  // prdata only moves on a completed read; writes and aborted transfers leave it alone.
  always_comb begin
    prdata_d = prdata_q;
    if (rd_en) begin
      prdata_d = in_range ? mem[mem_idx] : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q  <= S_IDLE;
      wcnt_q   <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      prdata_q <= prdata_d;
    end
  end

  // NOTE: the RAM array is deliberately not reset; clearing it would prevent mapping onto RAM macros.
  always_ff @(posedge pclk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (lane_we[i]) begin
          mem[mem_idx][8*i +: 8] <= bus.pwdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready;
  assign bus.pslverr = pready && !in_range;

endmodule

// File: tb/tb_apb_ram_param.sv
// Self-checking bench for apb_ram_param: directed scenarios plus randomized APB traffic
// checked against a word-array reference model of the RAM.
`timescale 1ns/1ps
module tb_apb_ram_param;

  localparam int DW     = 32;
  localparam int AW     = 12;
  localparam int DEPTH  = 256;
  localparam int WS     = 2;
  localparam int SW     = DW / 8;
  localparam int LSB    = $clog2(SW);
  localparam int CLK_P  = 10;

  logic pclk = 1'b0;
  logic preset;

  always #(CLK_P/2) pclk = ~pclk;

  apb_ram_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  apb_ram_param #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (DEPTH),
    .WAIT_STATES(WS)
  ) u_dut (
    .pclk  (pclk),
    .preset(preset),
    .bus   (bus)
  );

  // Reference model: the RAM as a plain word array plus the last completed read value.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_prdata;

  int  n_checks = 0;
  int  n_pass   = 0;
  time last_rdy_t;
  bit  b2b_mode;
  bit  last_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive_idle();
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;
`ifdef APB_RAM_STRB_EN
    bus.pstrb   = '0;
`endif
  endtask

  // One complete transfer. Entered and left one time unit after a rising edge; the
  // setup phase is driven immediately, so consecutive calls are back-to-back.
  task automatic apb_xfer(input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [SW-1:0] strb);
    int idx;
    bit in_rng;
    bit seen;
    int waits;
    idx    = int'(addr) >> LSB;
    in_rng = (idx < DEPTH);
    seen   = 1'b0;
    waits  = 0;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = data;
`ifdef APB_RAM_STRB_EN
    bus.pstrb   = strb;
`endif
    @(negedge pclk);
    check("setup_pready", bus.pready, 1'b0);
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    for (int c = 1; c <= WS + 5; c++) begin
      @(negedge pclk);
      if (bus.pready) begin
        seen  = 1'b1;
        waits = c;
        break;
      end
      @(posedge pclk); #1;
    end
    check("pready_timeout", bus.pready, 1'b1);
    if (seen) begin
      last_err = bus.pslverr;
      check("latency", waits, WS + 1);
      check("pslverr", bus.pslverr, !in_rng);
      if (b2b_mode && last_rdy_t != 0) check("b2b_gap", $time - last_rdy_t, (WS + 2) * CLK_P);
      last_rdy_t = $time;
      if (wr && in_rng) begin
        for (int i = 0; i < SW; i++)
          if (strb[i]) ref_mem[idx][8*i +: 8] = data[8*i +: 8];
      end
      if (!wr) ref_prdata = in_rng ? ref_mem[idx] : '0;
    end
    @(posedge pclk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    check(wr ? "prdata_after_wr" : "prdata_after_rd", bus.prdata, ref_prdata);
  endtask

  // Write of 0xA5A5A5A5 to index 4, killed in its 2nd access cycle by dropping penable or by reset.
  task automatic abort_write(input bit use_reset);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = AW'(4 * SW);
    bus.pwdata  = 32'hA5A5_A5A5;
`ifdef APB_RAM_STRB_EN
    bus.pstrb   = '1;
`endif
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    @(negedge pclk);
    check("abort_acc1_pready", bus.pready, 1'b0);
    @(posedge pclk); #1;
    if (use_reset) preset = 1'b1;
    else           bus.penable = 1'b0;
    @(negedge pclk);
    check("abort_acc2_pready", bus.pready, 1'b0);
    check("abort_acc2_pslverr", bus.pslverr, 1'b0);
    if (use_reset) begin
      ref_prdata = '0;
      check("abort_rst_prdata", bus.prdata, ref_prdata);
      preset = 1'b0;
    end
    @(posedge pclk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      check("abort_idle_pready", bus.pready, 1'b0);
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    #(CLK_P * 60000);
    $display("FAIL watchdog: run did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SW-1:0] strb;
    logic [AW-1:0] addr;
    bit            wr;

    last_rdy_t = 0;
    b2b_mode   = 1'b0;
    ref_prdata = '0;
    drive_idle();

    // Reset for two cycles, then idle for five.
    preset = 1'b1;
    repeat (2) begin
      @(negedge pclk);
      check("rst_prdata",  bus.prdata,  '0);
      check("rst_pready",  bus.pready,  1'b0);
      check("rst_pslverr", bus.pslverr, 1'b0);
    end
    @(posedge pclk); #1;
    preset = 1'b0;
    repeat (5) begin
      @(negedge pclk);
      check("idle_prdata",  bus.prdata,  '0);
      check("idle_pready",  bus.pready,  1'b0);
      check("idle_pslverr", bus.pslverr, 1'b0);
      @(posedge pclk); #1;
    end

    // Give every word a known value so the model never compares against X.
    for (int i = 0; i < DEPTH; i++) apb_xfer(1'b1, AW'(i * SW), DW'($urandom), '1);

    apb_xfer(1'b1, 12'h010, 32'hDEAD_BEEF, '1);
    check("wr_deadbeef_err", last_err, 1'b0);
    apb_xfer(1'b0, 12'h010, '0, '1);
    check("rd_deadbeef", bus.prdata, 32'hDEAD_BEEF);

    // Boundaries: index 256 errors, index 255 works, error reads return zero.
    apb_xfer(1'b1, 12'h400, 32'h1234_5678, '1);
    check("oor_wr_err", last_err, 1'b1);
    apb_xfer(1'b0, 12'h3FC, '0, '1);
    check("last_idx_err", last_err, 1'b0);
    apb_xfer(1'b1, 12'h3FC, 32'hCAFE_F00D, '1);
    apb_xfer(1'b0, 12'h3FE, '0, '1);
    check("last_idx_unaligned", bus.prdata, 32'hCAFE_F00D);
    apb_xfer(1'b0, 12'h400, '0, '1);
    check("oor_rd_err", last_err, 1'b1);
    check("oor_rd_zero", bus.prdata, '0);
    apb_xfer(1'b0, 12'hFFF, '0, '1);
    check("top_addr_err", last_err, 1'b1);
    apb_xfer(1'b0, 12'h000, '0, '1);

`ifdef APB_RAM_STRB_EN
    apb_xfer(1'b1, 12'h020, 32'hFFFF_FFFF, '1);
    apb_xfer(1'b1, 12'h020, 32'h0000_0000, 4'b0101);
    apb_xfer(1'b0, 12'h020, '0, 4'b0000);
    check("strb_merge", bus.prdata, 32'hFF00_FF00);
    apb_xfer(1'b1, 12'h020, 32'h1234_5678, 4'b0000);
    check("strb_none_err", last_err, 1'b0);
    apb_xfer(1'b0, 12'h020, '0, '1);
    check("strb_none_keep", bus.prdata, 32'hFF00_FF00);
`endif

    // Abort and reset in the middle of a write: index 4 keeps 0xDEADBEEF.
    abort_write(1'b0);
    apb_xfer(1'b0, 12'h010, '0, '1);
    check("abort_keep", bus.prdata, 32'hDEAD_BEEF);
    abort_write(1'b1);
    apb_xfer(1'b0, 12'h010, '0, '1);
    check("rst_abort_keep", bus.prdata, 32'hDEAD_BEEF);

    // Back-to-back writes to indexes 0..3, then reads, with no idle cycles in between.
    b2b_mode   = 1'b1;
    last_rdy_t = 0;
    for (int i = 0; i < 4; i++) apb_xfer(1'b1, AW'(i * SW), DW'(32'h1111_1111 * (i + 1)), '1);
    for (int i = 0; i < 4; i++) begin
      apb_xfer(1'b0, AW'(i * SW), '0, '1);
      check("b2b_rd", bus.prdata, DW'(32'h1111_1111 * (i + 1)));
    end
    b2b_mode = 1'b0;

    // Random traffic, mostly in range with some out-of-range and unaligned addresses.
    for (int n = 0; n < 150; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) addr = AW'($urandom);
      else                           addr = AW'($urandom_range(0, DEPTH * SW - 1));
`ifdef APB_RAM_STRB_EN
      strb = SW'($urandom);
`else
      strb = '1;
`endif
      apb_xfer(wr, addr, DW'($urandom), strb);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
